dct_2d_sequencer: RTL and testbench

Controller that drives the single 1-D `loeffler_dct_8` core through a full 8x8 2-D DCT: eight row passes from the pixel EBR into an intermediate EBR, then eight column passes from the intermediate EBR into the output EBR. It owns the core's reset, line and pass counters, and the transpose address mapping. It sits between the block-level JPEG control and the DCT core plus its three EBRs.

---
 rtl/dct2d_pkg.sv | 28 ++
 rtl/dct2d_addr_map.sv | 22 ++
 rtl/dct_2d_sequencer.sv | 148 ++++++++++++++
 tb/tb_dct_2d_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dct2d_pkg.sv
// Shared types and constants for the 2-D DCT sequencer: FSM states, pass
// encoding, index/EBR address widths and the transpose address helper.
package dct2d_pkg;

  localparam int IDX_W  = 3;
  localparam int ADDR_W = 6;

  localparam logic PASS_ROW = 1'b0;
  localparam logic PASS_COL = 1'b1;

  localparam logic [IDX_W-1:0] LAST_LINE = 3'd7;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CORE_RST = 3'd1,
    RUN      = 3'd2,
    NEXT     = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Row pass walks the row-major block; column pass reads it transposed.
  function automatic logic [ADDR_W-1:0] ebr_addr(input logic             pass,
                                                 input logic [IDX_W-1:0] line,
                                                 input logic [IDX_W-1:0] idx);
    return (pass == PASS_COL) ? {idx, line} : {line, idx};
  endfunction

endpackage

// File: rtl/dct2d_addr_map.sv
// Combinational transpose mapping from core element indices to EBR addresses
// and EBR selects; sits directly in the core's address path.
module dct2d_addr_map
  import dct2d_pkg::*;
(
  input  logic              pass,
  input  logic [IDX_W-1:0]  line,
  input  logic [IDX_W-1:0]  core_fetch_addr,
  input  logic [IDX_W-1:0]  core_result_addr,
  output logic [ADDR_W-1:0] src_raddr,
  output logic [ADDR_W-1:0] dst_waddr,
  output logic              src_sel,
  output logic              dst_sel
);

  // Row pass: pixel EBR -> intermediate; column pass: intermediate -> output.
  assign src_raddr = ebr_addr(pass, line, core_fetch_addr);
  assign dst_waddr = ebr_addr(pass, line, core_result_addr);
  assign src_sel   = pass;
  assign dst_sel   = pass;

endmodule

// File: rtl/dct_2d_sequencer.sv
// Drives one 1-D DCT core through 8 row passes and 8 column passes of an 8x8
// block. Optional per-line watchdog enabled by defining DCT2D_WATCHDOG_EN.
module dct_2d_sequencer
  import dct2d_pkg::*;
#(
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              pass,
  output logic [IDX_W-1:0]  line,
  output logic              core_nreset,
  input  logic              core_done,
  input  logic [IDX_W-1:0]  core_fetch_addr,
  input  logic [IDX_W-1:0]  core_result_addr,
  input  logic              core_result_wren,
  output logic [ADDR_W-1:0] src_raddr,
  output logic              src_sel,
  output logic [ADDR_W-1:0] dst_waddr,
  output logic              dst_sel,
  output logic              dst_wren
);

  if (RESET_CYCLES < 1 || RESET_CYCLES > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("dct_2d_sequencer: RESET_CYCLES must be 1..15, TIMEOUT_CYCLES >= 1");
  end

  localparam logic [3:0] RST_LAST = 4'(RESET_CYCLES - 1);

  state_t     state;
  logic [3:0] rst_cnt;
  logic       run_first;
  logic       core_done_ok;
  logic       wd_expire;

  // The first RUN cycle sees whatever core_done was left over from before reset.
  assign core_done_ok = (state == RUN) && !run_first && core_done;

`ifdef DCT2D_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  assign wd_expire = (state == RUN) && !core_done_ok && (wd_cnt == WD_LAST);
  assign error     = err_q;

  always_ff @(posedge clock) begin
    if (!nreset || state != RUN) wd_cnt <= '0;
    else if (wd_cnt != WD_LAST)  wd_cnt <= wd_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!nreset)                    err_q <= 1'b0;
    else if (state == IDLE && start) err_q <= 1'b0;
    else if (wd_expire)             err_q <= 1'b1;
  end
`else
  assign wd_expire = 1'b0;
  assign error     = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= PASS_ROW;
      line        <= '0;
      core_nreset <= 1'b0;
      rst_cnt     <= '0;
      run_first   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CORE_RST;
            busy    <= 1'b1;
            pass    <= PASS_ROW;
            line    <= '0;
            rst_cnt <= '0;
          end
        end
        CORE_RST: begin
          if (rst_cnt == RST_LAST) begin
            state       <= RUN;
            core_nreset <= 1'b1;
            run_first   <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        RUN: begin
          run_first <= 1'b0;
          if (core_done_ok) begin
            state       <= NEXT;
            core_nreset <= 1'b0;
          end else if (wd_expire) begin
            // Abort pulses done now; DONE then only returns to IDLE.
            state       <= DONE;
            core_nreset <= 1'b0;
            done        <= 1'b1;
          end
        end
        NEXT: begin
          rst_cnt <= '0;
          if (line != LAST_LINE) begin
            line  <= line + 1'b1;
            state <= CORE_RST;
          end else if (pass == PASS_ROW) begin
            pass  <= PASS_COL;
            line  <= '0;
            state <= CORE_RST;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          done  <= !error;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dst_wren = (state == RUN) && core_result_wren;

  dct2d_addr_map u_addr_map (
    .pass             (pass),
    .line             (line),
    .core_fetch_addr  (core_fetch_addr),
    .core_result_addr (core_result_addr),
    .src_raddr        (src_raddr),
    .dst_waddr        (dst_waddr),
    .src_sel          (src_sel),
    .dst_sel          (dst_sel)
  );

endmodule

// File: tb/tb_dct_2d_sequencer.sv
// Bench for dct_2d_sequencer: behavioural core model, write-address scoreboard,
// table-driven transpose probes and multi-cycle corner sequences.
module tb_dct_2d_sequencer;

  localparam int RST_C = 2;
  localparam int TO_C  = 20;
  localparam int T_RUN = 10;
  localparam int LAT   = 16 * (RST_C + T_RUN + 1) + 2;
  localparam int LAT_HELD = 16 * (RST_C + 2 + 1) + 2;

  logic       clock = 1'b0;
  logic       nreset = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, error, pass, core_nreset;
  logic [2:0] line;
  logic       core_done, core_result_wren;
  logic [2:0] core_fetch_addr, core_result_addr;
  logic [5:0] src_raddr, dst_waddr;
  logic       src_sel, dst_sel, dst_wren;

  always #5 clock = ~clock;

  dct_2d_sequencer #(.RESET_CYCLES(RST_C), .TIMEOUT_CYCLES(TO_C)) dut (
    .clock(clock), .nreset(nreset), .start(start), .busy(busy), .done(done),
    .error(error), .pass(pass), .line(line), .core_nreset(core_nreset),
    .core_done(core_done), .core_fetch_addr(core_fetch_addr),
    .core_result_addr(core_result_addr), .core_result_wren(core_result_wren),
    .src_raddr(src_raddr), .src_sel(src_sel), .dst_waddr(dst_waddr),
    .dst_sel(dst_sel), .dst_wren(dst_wren)
  );

  // Core model: mode 0 = done T_RUN cycles after reset release, 1 = never, 2 = held high.
  int         mode = 0;
  int         mcnt = 0;
  bit         ovr = 1'b0;
  logic [2:0] ovr_f = '0, ovr_r = '0;

  always @(posedge clock) begin
    if (!core_nreset) mcnt <= 0;
    else if (mcnt < 1000) mcnt <= mcnt + 1;
  end

  assign core_done        = (mode == 2) || (mode == 0 && mcnt >= T_RUN - 1);
  assign core_result_wren = core_nreset && mcnt >= 1 && mcnt <= 8;
  assign core_result_addr = ovr ? ovr_r : (core_nreset ? 3'(mcnt - 1) : 3'd0);
  assign core_fetch_addr  = ovr ? ovr_f : (core_nreset ? 3'(mcnt) : 3'd0);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct packed { logic sel; logic [5:0] addr; } wr_t;
  wr_t sb_q[$];
  bit  sb_en = 1'b0;
  int  done_cnt = 0;

  always @(negedge clock) begin
    if (nreset && dst_wren && sb_en) begin
      if (sb_q.size() == 0) chk("sb_extra_write", {25'd0, dst_sel, dst_waddr}, 32'hFFFF_FFFF);
      else                  chk("sb_waddr", {25'd0, dst_sel, dst_waddr}, {25'd0, sb_q.pop_front()});
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic push_block();
    for (int p = 0; p < 2; p++)
      for (int l = 0; l < 8; l++)
        for (int k = 0; k < 8; k++)
          sb_q.push_back(wr_t'{sel: 1'(p), addr: (p != 0) ? 6'(k * 8 + l) : 6'(l * 8 + k)});
  endtask

  task automatic chk_reset(input string nm);
    chk(nm, {busy, done, error, pass, line, core_nreset, dst_wren, src_sel, dst_sel,
             src_raddr, dst_waddr}, 32'd0);
  endtask

  task automatic start_pulse();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic run_block(input int exp_lat, input bit exp_err, input bit poke);
    int lat;
    bit busy_ok;
    int d0;
    d0 = done_cnt;
    start_pulse();
    chk("busy_rise", busy, 1);
    chk("err_cleared", error, 0);
    lat = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 3000) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      start = poke && (lat == 50);
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, exp_lat);
    chk("busy_held", busy_ok, 1);
    chk("error_at_done", error, exp_err);
    @(negedge clock);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    chk("done_count", done_cnt - d0, 1);
    if (sb_en) chk("sb_drained", sb_q.size(), 0);
  endtask

  typedef struct { bit p; int l; int f; int r; int exp_src; int exp_dst; } probe_t;
  probe_t tbl[6];

  initial begin
    int g;
    int d0;
    tbl[0] = '{p: 0, l: 0, f: 7, r: 0, exp_src: 'h07, exp_dst: 'h00};
    tbl[1] = '{p: 0, l: 3, f: 6, r: 5, exp_src: 'h1E, exp_dst: 'h1D};
    tbl[2] = '{p: 0, l: 7, f: 7, r: 7, exp_src: 'h3F, exp_dst: 'h3F};
    tbl[3] = '{p: 1, l: 0, f: 1, r: 2, exp_src: 'h08, exp_dst: 'h10};
    tbl[4] = '{p: 1, l: 3, f: 6, r: 5, exp_src: 'h33, exp_dst: 'h2B};
    tbl[5] = '{p: 1, l: 7, f: 0, r: 7, exp_src: 'h07, exp_dst: 'h3F};

    repeat (3) @(negedge clock);
    chk_reset("reset_values");
    nreset = 1'b1;
    repeat (2) @(negedge clock);
    chk_reset("idle_values");

    // Plain block with full write-address scoreboard.
    sb_en = 1'b1;
    push_block();
    run_block(LAT, 1'b0, 1'b0);

    // start pulsed mid-block must not disturb anything.
    push_block();
    run_block(LAT, 1'b0, 1'b1);
    repeat (5) @(negedge clock);
    chk("no_restart", busy, 0);

    // Transpose probes: override core addresses at chosen pass/line.
    sb_en = 1'b0;
    d0 = done_cnt;
    start_pulse();
    for (int i = 0; i < 6; i++) begin
      g = 0;
      while (!(core_nreset === 1'b1 && pass === tbl[i].p && line === 3'(tbl[i].l)) && g < 3000) begin
        @(negedge clock);
        g++;
      end
      chk("probe_reached", g < 3000, 1);
      ovr_f = 3'(tbl[i].f);
      ovr_r = 3'(tbl[i].r);
      ovr = 1'b1;
      #1;
      chk("probe_src_raddr", src_raddr, tbl[i].exp_src);
      chk("probe_dst_waddr", dst_waddr, tbl[i].exp_dst);
      chk("probe_sels", {src_sel, dst_sel}, {tbl[i].p, tbl[i].p});
      ovr = 1'b0;
    end
    g = 0;
    while (done !== 1'b1 && g < 3000) begin
      @(negedge clock);
      g++;
    end
    chk("probe_block_done", done, 1);
    @(negedge clock);
    chk("probe_done_count", done_cnt - d0, 1);

    // Reset for one cycle at cycle 100 of a block.
    d0 = done_cnt;
    start_pulse();
    repeat (99) @(negedge clock);
    nreset = 1'b0;
    @(negedge clock) nreset = 1'b1;
    chk_reset("mid_block_reset");
    repeat (RST_C + T_RUN + 20) @(negedge clock);
    chk("no_done_after_abort", done_cnt - d0, 0);
    chk("stays_idle", busy, 0);
    sb_en = 1'b1;
    push_block();
    run_block(LAT, 1'b0, 1'b0);

    // core_done held high: first RUN cycle masked, so two RUN cycles per line.
    sb_en = 1'b0;
    mode = 2;
    run_block(LAT_HELD, 1'b0, 1'b0);
    mode = 0;

`ifdef DCT2D_WATCHDOG_EN
    mode = 1;
    run_block(RST_C + TO_C + 1, 1'b1, 1'b0);
    repeat (3) @(negedge clock);
    chk("error_sticky", error, 1);
    mode = 0;
    sb_en = 1'b1;
    push_block();
    run_block(LAT, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
